// File: rtl/prog_seq_detector.sv
// Programmable serial sequence detector.
// Shifts accepted bits into an N-bit history and compares it against a
// latched pattern once N bits are present. Overlapping or non-overlapping
// detection is selected by the latched overlap flag. Matches produce a
// registered single-cycle pulse on z and bump a saturating counter.
module prog_seq_detector #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic [N-1:0]     pattern,
  input  logic             load,
  input  logic             overlap_en,
  input  logic             clr_cnt,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int FW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_ARMED = 2'd2;

  localparam logic [FW-1:0]    FILL_MAX = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]    state, state_n;
  logic [N-1:0]  hist, hist_n, hist_sh;
  logic [FW-1:0] fill, fill_n, fill_inc;
  logic [N-1:0]  pat_q;
  logic          ovl_q;
  logic          accept;
  logic          hit;

  // Bits are only taken once a pattern exists; load wins over data.
  assign accept   = x_valid && !load && (state != S_IDLE);
  assign hist_sh  = {hist[N-2:0], x};
  assign fill_inc = (fill == FILL_MAX) ? fill : fill + 1'b1;
  // Compare the post-shift view so the completing bit counts this edge.
  assign hit      = accept && (fill_inc == FILL_MAX) && (hist_sh == pat_q);

  // Next-state logic for control FSM, history and fill count.
  always_comb begin
    state_n = state;
    hist_n  = hist;
    fill_n  = fill;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_n = S_FILL;
          fill_n  = '0;
        end
      end
      S_FILL, S_ARMED: begin
        if (load) begin
          state_n = S_FILL;
          fill_n  = '0;
        end else if (accept) begin
          hist_n = hist_sh;
          if (hit && !ovl_q) begin
            // Non-overlap: next match must be built from N fresh bits.
            fill_n  = '0;
            state_n = S_FILL;
          end else begin
            fill_n  = fill_inc;
            state_n = (fill_inc == FILL_MAX) ? S_ARMED : S_FILL;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        fill_n  = '0;
      end
    endcase
  end

  // Control state, history and fill registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      hist  <= '0;
      fill  <= '0;
    end else begin
      state <= state_n;
      hist  <= hist_n;
      fill  <= fill_n;
    end
  end

  // Latched copy of pattern and overlap mode; the live ports are ignored
  // between loads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= '0;
      ovl_q <= 1'b1;
    end else if (load) begin
      pat_q <= pattern;
      ovl_q <= overlap_en;
    end
  end

  // Registered outputs: match pulse, saturating counter, armed flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z         <= 1'b0;
      match_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      z     <= hit;
      armed <= (fill_n == FILL_MAX);
      if (clr_cnt)
        match_cnt <= '0;
      else if (hit && (match_cnt != CNT_MAX))
        match_cnt <= match_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_seq_detector.sv
// Bench for prog_seq_detector: directed scenarios with literal expectations
// followed by randomized traffic checked every cycle against a bit-queue model.
module tb_prog_seq_detector;

  localparam int N     = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             x = 1'b0;
  logic             x_valid = 1'b0;
  logic [N-1:0]     pattern = '0;
  logic             load = 1'b0;
  logic             overlap_en = 1'b0;
  logic             clr_cnt = 1'b0;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  int n_chk = 0;
  int n_err = 0;

  prog_seq_detector #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .pattern(pattern),
    .load(load), .overlap_en(overlap_en), .clr_cnt(clr_cnt),
    .z(z), .match_cnt(match_cnt), .armed(armed)
  );

  always #5 clk = ~clk;

  // Reference model: accepted bits kept as a queue, matched by value.
  bit m_loaded = 1'b0;
  int m_pat    = 0;
  bit m_ovl    = 1'b1;
  bit m_q[$];
  int m_fill   = 0;
  int m_cnt    = 0;
  bit m_z      = 1'b0;

  function automatic int hist_val();
    int v = 0;
    foreach (m_q[i]) v = (v << 1) | int'(m_q[i]);
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit hit;
    if (!rst) begin
      m_loaded = 1'b0; m_pat = 0; m_ovl = 1'b1; m_q.delete();
      m_fill = 0; m_cnt = 0; m_z = 1'b0;
    end else begin
      hit = 1'b0;
      if (load) begin
        m_pat = int'(pattern); m_ovl = overlap_en; m_fill = 0; m_loaded = 1'b1;
      end else if (x_valid && m_loaded) begin
        m_q.push_back(x);
        if (m_q.size() > N) m_q.delete(0);
        if (m_fill < N) m_fill++;
        if (m_fill == N && hist_val() == m_pat) hit = 1'b1;
        if (hit && !m_ovl) m_fill = 0;
      end
      m_z = hit;
      if (clr_cnt) m_cnt = 0;
      else if (hit && m_cnt < CMAX) m_cnt++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_z", int'(z), int'(m_z));
    chk("cyc_cnt", int'(match_cnt), m_cnt);
    chk("cyc_armed", int'(armed), int'(m_fill == N));
  end

  // One clock: apply inputs, take the edge, return just after it.
  task automatic cyc(input logic l, input logic v, input logic xb, input logic c);
    load = l; x_valid = v; x = xb; clr_cnt = c;
    @(posedge clk); #1;
    load = 1'b0; x_valid = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic do_load(input logic [N-1:0] p, input logic o);
    pattern = p; overlap_en = o;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    pattern = ~p; overlap_en = ~o;  // live ports must not matter after load
  endtask

  logic [6:0] s7;
  logic [6:0] zs;
  int pulses;
  logic zlast;

  initial begin
    #12;
    chk("rst_z", int'(z), 0);
    chk("rst_cnt", int'(match_cnt), 0);
    chk("rst_armed", int'(armed), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Before any load the detector ignores data (reset pattern 0000 would match).
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_z", int'(z), 0);
    chk("idle_armed", int'(armed), 0);

    // Overlapping detection.
    s7 = 7'b0110110;
    do_load(4'b0110, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b0, 1'b1, s7[i], 1'b0);
      zs[6-i] = z;
    end
    chk("ovl_z", int'(zs), int'(7'b1001000));
    chk("ovl_cnt", int'(match_cnt), 2);

    // Non-overlapping detection.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    do_load(4'b0110, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      cyc(1'b0, 1'b1, s7[i], 1'b0);
      zs[6-i] = z;
    end
    chk("novl_z", int'(zs), int'(7'b0001000));
    chk("novl_cnt", int'(match_cnt), 1);

    // Gaps between valid bits.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    do_load(4'b0110, 1'b1);
    pulses = 0; zlast = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] g;
      g = 4'b0110;
      cyc(1'b0, 1'b1, g[i], 1'b0);
      pulses += int'(z);
      if (i == 0) zlast = z;
      for (int k = 0; k < 2; k++) begin
        cyc(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0);
        pulses += int'(z);
      end
    end
    chk("gap_pulses", pulses, 1);
    chk("gap_zlast", int'(zlast), 1);

    // Reload mid-stream restarts the fill count.
    do_load(4'b0110, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    do_load(4'b0110, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reload_z", int'(z), 0);
    chk("reload_armed", int'(armed), 0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("reload_armed3", int'(armed), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("reload_z4", int'(z), 1);
    chk("reload_armed4", int'(armed), 1);

    // Counter saturation and clear priority.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    do_load(4'b0110, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int m = 0; m < 4; m++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
    chk("sat_cnt", int'(match_cnt), 3);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_z", int'(z), 1);
    chk("clr_cnt", int'(match_cnt), 0);

    // Asynchronous reset while armed with a pulse on z.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_z", int'(z), 1);
    chk("pre_rst_cnt", int'(match_cnt), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_z", int'(z), 0);
    chk("arst_cnt", int'(match_cnt), 0);
    chk("arst_armed", int'(armed), 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("post_rst_z", int'(z), 0);
    chk("post_rst_armed", int'(armed), 0);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299) == 0) begin
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
      end else begin
        logic l;
        l = ($urandom_range(15) == 0);
        if (l) begin
          pattern = 4'($urandom);
          overlap_en = 1'($urandom);
        end
        cyc(l, ($urandom_range(3) != 0), 1'($urandom), ($urandom_range(39) == 0));
        if (!l) begin
          pattern = 4'($urandom);
          overlap_en = 1'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
